// File: rtl/wisc_ctrl_pkg.sv
// Shared control definitions: opcodes, ALU function codes (also used by
// the EX-stage control), FSM states and the decoded-instruction bundle.
package wisc_ctrl_pkg;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;
    localparam logic [4:0] OP_J    = 5'b00100;
    localparam logic [4:0] OP_JR   = 5'b00101;
    localparam logic [4:0] OP_JAL  = 5'b00110;
    localparam logic [4:0] OP_JALR = 5'b00111;
    localparam logic [4:0] OP_ST   = 5'b10000;
    localparam logic [4:0] OP_LD   = 5'b10001;
    localparam logic [4:0] OP_SLBI = 5'b10010;
    localparam logic [4:0] OP_STU  = 5'b10011;
    localparam logic [4:0] OP_LBI  = 5'b11000;
    localparam logic [4:0] OP_BTR  = 5'b11001;
    localparam logic [4:0] OP_RR_B = 5'b11010;
    localparam logic [4:0] OP_RR_A = 5'b11011;

    localparam logic [4:0] ALU_IMM_A = 5'b00000;
    localparam logic [4:0] ALU_IMM_B = 5'b00100;
    localparam logic [4:0] ALU_MEM   = 5'b01000;
    localparam logic [4:0] ALU_BTR   = 5'b01001;
    localparam logic [4:0] ALU_RR_A  = 5'b01010;
    localparam logic [4:0] ALU_RR_B  = 5'b01110;
    localparam logic [4:0] ALU_SET   = 5'b10010;
    localparam logic [4:0] ALU_BR    = 5'b10110;
    localparam logic [4:0] ALU_LBI   = 5'b11010;
    localparam logic [4:0] ALU_SLBI  = 5'b11011;
    localparam logic [4:0] ALU_JMP   = 5'b11100;
    localparam logic [4:0] ALU_JREG  = 5'b11101;
    localparam logic [4:0] ALU_NOP   = 5'b11111;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERR
    } state_e;

    typedef struct packed {
        logic       illegal;
        logic       halt;
        logic       is_mem;
        logic       is_store;
        logic       wr_reg;
        logic [1:0] wb_sel;
    } ctrl_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decode: ALU function code plus the
// memory / register-writer / writeback classification of an instruction.
module instr_decode
    import wisc_ctrl_pkg::*;
(
    input  logic [15:0] instr_i,
    output logic [4:0]  alu_fn_o,
    output ctrl_t       ctrl_o
);

    logic [4:0] op;
    logic [4:0] funct;
    logic       unused_bits;

    assign op          = instr_i[15:11];
    assign funct       = {3'b000, instr_i[1:0]};
    assign unused_bits = ^instr_i[10:2];

    // Map opcode/funct to ALU function and control class
    always_comb begin
        alu_fn_o = ALU_NOP;
        ctrl_o   = '0;
        unique casez (op)
            5'b010??: begin
                alu_fn_o      = ALU_IMM_A + {3'b000, op[1:0]};
                ctrl_o.wr_reg = 1'b1;
            end
            5'b101??: begin
                alu_fn_o      = ALU_IMM_B + {3'b000, op[1:0]};
                ctrl_o.wr_reg = 1'b1;
            end
            OP_ST: begin
                alu_fn_o        = ALU_MEM;
                ctrl_o.is_mem   = 1'b1;
                ctrl_o.is_store = 1'b1;
            end
            OP_LD: begin
                alu_fn_o      = ALU_MEM;
                ctrl_o.is_mem = 1'b1;
                ctrl_o.wr_reg = 1'b1;
                ctrl_o.wb_sel = WB_MEM;
            end
            OP_STU: begin
                alu_fn_o        = ALU_MEM;
                ctrl_o.is_mem   = 1'b1;
                ctrl_o.is_store = 1'b1;
                ctrl_o.wr_reg   = 1'b1;
            end
            OP_SLBI: begin
                alu_fn_o      = ALU_SLBI;
                ctrl_o.wr_reg = 1'b1;
            end
            OP_LBI: begin
                alu_fn_o      = ALU_LBI;
                ctrl_o.wr_reg = 1'b1;
            end
            OP_BTR: begin
                alu_fn_o      = ALU_BTR;
                ctrl_o.wr_reg = 1'b1;
            end
            OP_RR_A: begin
                alu_fn_o      = ALU_RR_A + funct;
                ctrl_o.wr_reg = 1'b1;
            end
            OP_RR_B: begin
                alu_fn_o      = ALU_RR_B + funct;
                ctrl_o.wr_reg = 1'b1;
            end
            5'b111??: begin
                alu_fn_o      = ALU_SET + {3'b000, op[1:0]};
                ctrl_o.wr_reg = 1'b1;
            end
            5'b011??: alu_fn_o = ALU_BR + {3'b000, op[1:0]};
            OP_J:     alu_fn_o = ALU_JMP;
            OP_JR:    alu_fn_o = ALU_JREG;
            OP_JAL: begin
                alu_fn_o      = ALU_JMP;
                ctrl_o.wr_reg = 1'b1;
                ctrl_o.wb_sel = WB_PC;
            end
            OP_JALR: begin
                alu_fn_o      = ALU_JREG;
                ctrl_o.wr_reg = 1'b1;
                ctrl_o.wb_sel = WB_PC;
            end
            OP_HALT:  ctrl_o.halt = 1'b1;
            OP_NOP:   alu_fn_o = ALU_NOP;
            5'b0001?: ctrl_o.illegal = 1'b1;
            default:  ctrl_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control sequencer FETCH/DECODE/EXECUTE/MEM/WB with HALT/ERR.
// Define MEM_TIMEOUT_EN to bound imem/dmem waits by MEM_TIMEOUT cycles.
module control_fsm #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        ir_ld,
    output logic        imem_en,
    output logic [4:0]  ALU_fn,
    output logic        dmem_en,
    output logic        dmem_wr,
    output logic        reg_wr_en,
    output logic [1:0]  wb_sel,
    output logic        pc_en,
    output logic        halt,
    output logic        err
);
    import wisc_ctrl_pkg::*;

    if (MEM_TIMEOUT < 2) begin : g_bad_timeout
        $error("MEM_TIMEOUT must be at least 2");
    end

    state_e     state_q;
    ctrl_t      ctrl_q;
    ctrl_t      dec_ctrl;
    logic [4:0] dec_alu;
    logic [4:0] alu_fn_q;
    logic [1:0] wb_sel_q;
    logic       imem_en_q;
    logic       dmem_en_q;
    logic       dmem_wr_q;
    logic       pc_en_q;
    logic       reg_wr_q;
    logic       halt_q;
    logic       err_q;

`ifdef MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    logic [WAIT_W-1:0] wait_q;
`endif

    instr_decode u_dec (
        .instr_i  (instr),
        .alu_fn_o (dec_alu),
        .ctrl_o   (dec_ctrl)
    );

    // Sequencer; outputs are registered for the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ctrl_q    <= '0;
            alu_fn_q  <= ALU_NOP;
            wb_sel_q  <= WB_ALU;
            imem_en_q <= 1'b1;
            dmem_en_q <= 1'b0;
            dmem_wr_q <= 1'b0;
            pc_en_q   <= 1'b0;
            reg_wr_q  <= 1'b0;
            halt_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_q    <= '0;
`endif
        end else begin
            pc_en_q  <= 1'b0;
            reg_wr_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_q   <= '0;
`endif
            unique case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        state_q   <= S_DECODE;
                        imem_en_q <= 1'b0;
                        ctrl_q    <= dec_ctrl;
                        alu_fn_q  <= dec_alu;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_q == WAIT_LAST) begin
                        state_q   <= S_ERR;
                        imem_en_q <= 1'b0;
                        err_q     <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
`endif
                end
                S_DECODE: begin
                    if (ctrl_q.illegal) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                    end else if (ctrl_q.halt) begin
                        state_q <= S_HALT;
                        halt_q  <= 1'b1;
                    end else begin
                        state_q <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (ctrl_q.is_mem) begin
                        state_q   <= S_MEM;
                        dmem_en_q <= 1'b1;
                        dmem_wr_q <= ctrl_q.is_store;
                    end else begin
                        state_q  <= S_WB;
                        pc_en_q  <= 1'b1;
                        reg_wr_q <= ctrl_q.wr_reg;
                        wb_sel_q <= ctrl_q.wb_sel;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        state_q   <= S_WB;
                        dmem_en_q <= 1'b0;
                        dmem_wr_q <= 1'b0;
                        pc_en_q   <= 1'b1;
                        reg_wr_q  <= ctrl_q.wr_reg;
                        wb_sel_q  <= ctrl_q.wb_sel;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_q == WAIT_LAST) begin
                        state_q   <= S_ERR;
                        dmem_en_q <= 1'b0;
                        dmem_wr_q <= 1'b0;
                        err_q     <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
`endif
                end
                S_WB: begin
                    state_q   <= S_FETCH;
                    imem_en_q <= 1'b1;
                    wb_sel_q  <= WB_ALU;
                end
                S_HALT: state_q <= S_HALT;
                S_ERR:  state_q <= S_ERR;
                default: begin
                    state_q <= S_ERR;
                    err_q   <= 1'b1;
                end
            endcase
        end
    end

    assign ir_ld     = imem_en_q & imem_ready;
    assign imem_en   = imem_en_q;
    assign ALU_fn    = alu_fn_q;
    assign dmem_en   = dmem_en_q;
    assign dmem_wr   = dmem_wr_q;
    assign reg_wr_en = reg_wr_q;
    assign wb_sel    = wb_sel_q;
    assign pc_en     = pc_en_q;
    assign halt      = halt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: directed scenarios plus a
// randomized instruction stream checked against a behavioural model.
module tb_control_fsm;

    localparam int O_IMEM = 14;
    localparam int O_IRLD = 13;
    localparam int O_DEN  = 12;
    localparam int O_DWR  = 11;
    localparam int O_PC   = 10;
    localparam int O_RW   = 9;
    localparam int O_HALT = 6;
    localparam int O_ERR  = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = '0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        ir_ld, imem_en, dmem_en, dmem_wr;
    logic        reg_wr_en, pc_en, halt, err;
    logic [4:0]  ALU_fn;
    logic [1:0]  wb_sel;

    int checks = 0;
    int errors = 0;

    control_fsm #(.MEM_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .ir_ld      (ir_ld),
        .imem_en    (imem_en),
        .ALU_fn     (ALU_fn),
        .dmem_en    (dmem_en),
        .dmem_wr    (dmem_wr),
        .reg_wr_en  (reg_wr_en),
        .wb_sel     (wb_sel),
        .pc_en      (pc_en),
        .halt       (halt),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- behavioural reference ----------------
    function automatic logic [4:0] m_alu(input logic [15:0] i);
        int op, f, r;
        op = int'(i[15:11]);
        f  = int'(i[1:0]);
        r  = 31;
        if (op >= 8 && op <= 11)       r = op - 8;
        else if (op >= 20 && op <= 23) r = op - 16;
        else if (op inside {16, 17, 19}) r = 8;
        else if (op == 25)             r = 9;
        else if (op == 27)             r = 10 + f;
        else if (op == 26)             r = 14 + f;
        else if (op >= 28)             r = 18 + (op - 28);
        else if (op >= 12 && op <= 15) r = 22 + (op - 12);
        else if (op == 24)             r = 26;
        else if (op == 18)             r = 27;
        else if (op == 4 || op == 6)   r = 28;
        else if (op == 5 || op == 7)   r = 29;
        return 5'(r);
    endfunction

    function automatic bit m_writes(input int op);
        return op inside {[8:11], [20:23], 17, 19, 25, 26, 27,
                          [28:31], 24, 18, 6, 7};
    endfunction

    function automatic logic [1:0] m_wbsel(input int op);
        if (op == 17) return 2'b01;
        if (op == 6 || op == 7) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [14:0] obs();
        return {imem_en, ir_ld, dmem_en, dmem_wr, pc_en, reg_wr_en,
                wb_sel, halt, err, ALU_fn};
    endfunction

    // Drive one cycle of inputs, sample outputs, advance to next cycle
    task automatic cyc(input logic ir, input logic dr,
                       output logic [14:0] o);
        imem_ready = ir;
        dmem_ready = dr;
        #1;
        o = obs();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [14:0] o;
        apply_reset();
        cyc(1'b0, 1'b1, o);
        checks++;
        if (o !== {1'b1, 1'b0, 4'b0000, 2'b00, 2'b00, 5'b11111}) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", o,
                     {1'b1, 1'b0, 4'b0000, 2'b00, 2'b00, 5'b11111});
        end
    endtask

    task automatic test_add();
        logic [14:0] o1, o2, o3, o4, o5;
        apply_reset();
        instr = 16'hD8E0;
        cyc(1'b1, 1'b0, o1);
        instr = 16'h0000;
        cyc(1'b0, 1'b0, o2);
        cyc(1'b0, 1'b0, o3);
        cyc(1'b0, 1'b0, o4);
        cyc(1'b0, 1'b0, o5);
        checks++;
        if (o1[O_IRLD] !== 1'b1 || o1[O_IMEM] !== 1'b1) begin
            errors++;
            $display("FAIL add_fetch: got %h want ir_ld=1 imem_en=1", o1);
        end
        checks++;
        if (o2[4:0] !== 5'b01010 || o3[4:0] !== 5'b01010) begin
            errors++;
            $display("FAIL add_alu_fn: got %b/%b want 01010",
                     o2[4:0], o3[4:0]);
        end
        checks++;
        if (o3[O_PC] !== 1'b0 || o3[O_RW] !== 1'b0) begin
            errors++;
            $display("FAIL add_early_strobe: got %h want no pc_en/reg_wr", o3);
        end
        checks++;
        if (o4[O_PC] !== 1'b1 || o4[O_RW] !== 1'b1 || o4[8:7] !== 2'b00
            || o4[4:0] !== 5'b01010) begin
            errors++;
            $display("FAIL add_wb: got %h want pc_en=1 reg_wr=1 wb=00", o4);
        end
        checks++;
        if (o5[O_IMEM] !== 1'b1 || o5[O_PC] !== 1'b0) begin
            errors++;
            $display("FAIL add_refetch: got %h want imem_en=1 pc_en=0", o5);
        end
    endtask

    task automatic test_load();
        logic [14:0] o;
        int n_mem;
        apply_reset();
        instr = 16'h8C20;
        cyc(1'b1, 1'b0, o);
        cyc(1'b0, 1'b1, o);
        cyc(1'b0, 1'b1, o);
        n_mem = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, (k == 3), o);
            if (o[O_DEN] === 1'b1 && o[O_DWR] === 1'b0 &&
                o[4:0] === 5'b01000)
                n_mem++;
        end
        checks++;
        if (n_mem != 4) begin
            errors++;
            $display("FAIL ld_mem_cycles: got %0d want 4", n_mem);
        end
        cyc(1'b0, 1'b0, o);
        checks++;
        if (o[O_RW] !== 1'b1 || o[O_PC] !== 1'b1 || o[8:7] !== 2'b01
            || o[O_DEN] !== 1'b0 || o[4:0] !== 5'b01000) begin
            errors++;
            $display("FAIL ld_wb: got %h want reg_wr=1 pc_en=1 wb=01", o);
        end
    endtask

    task automatic test_halt();
        logic [14:0] o;
        int bad;
        apply_reset();
        instr = 16'h0000;
        cyc(1'b1, 1'b0, o);
        cyc(1'b1, 1'b1, o);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b1, o);
            if (o !== {4'b0000, 2'b00, 2'b00, 1'b1, 1'b0, 5'b11111})
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL halt_sticky: got %0d bad cycles want 0 (last %h)",
                     bad, o);
        end
    endtask

    task automatic test_illegal();
        logic [14:0] o;
        int bad;
        apply_reset();
        instr = 16'h1000;
        cyc(1'b1, 1'b0, o);
        cyc(1'b0, 1'b0, o);
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 1'b1, o);
            if (o[O_ERR] !== 1'b1 || o[O_HALT] !== 1'b0 || o[14:9] !== 6'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL err_sticky: got %0d bad cycles want 0 (last %h)",
                     bad, o);
        end
        apply_reset();
        cyc(1'b0, 1'b0, o);
        checks++;
        if (o[O_ERR] !== 1'b0 || o[O_IMEM] !== 1'b1) begin
            errors++;
            $display("FAIL err_reset: got %h want err=0 imem_en=1", o);
        end
    endtask

    task automatic test_rst_mid_mem();
        logic [14:0] o;
        apply_reset();
        instr = 16'h8C20;
        cyc(1'b1, 1'b0, o);
        cyc(1'b0, 1'b0, o);
        cyc(1'b0, 1'b0, o);
        cyc(1'b0, 1'b0, o);
        cyc(1'b0, 1'b0, o);
        rst = 1'b1;
        cyc(1'b0, 1'b1, o);
        rst = 1'b0;
        cyc(1'b0, 1'b0, o);
        checks++;
        if (o !== {1'b1, 1'b0, 4'b0000, 2'b00, 2'b00, 5'b11111}) begin
            errors++;
            $display("FAIL rst_mid_mem: got %h want %h", o,
                     {1'b1, 1'b0, 4'b0000, 2'b00, 2'b00, 5'b11111});
        end
    endtask

    task automatic test_timeout();
        logic [14:0] o;
        int n_mem;
        apply_reset();
        instr = 16'h8000;
        cyc(1'b1, 1'b0, o);
        cyc(1'b0, 1'b0, o);
        cyc(1'b0, 1'b0, o);
        n_mem = 0;
`ifdef MEM_TIMEOUT_EN
        for (int k = 0; k < 16; k++) begin
            cyc(1'b0, 1'b0, o);
            if (o[O_DEN] === 1'b1 && o[O_DWR] === 1'b1) n_mem++;
        end
        cyc(1'b0, 1'b0, o);
        checks++;
        if (n_mem != 16 || o[O_ERR] !== 1'b1 || o[O_DEN] !== 1'b0) begin
            errors++;
            $display("FAIL mem_timeout: got %0d wait cycles err=%b want 16 err=1",
                     n_mem, o[O_ERR]);
        end
`else
        for (int k = 0; k < 100; k++) begin
            cyc(1'b0, 1'b0, o);
            if (o[O_DEN] === 1'b1 && o[O_DWR] === 1'b1 && o[O_ERR] === 1'b0)
                n_mem++;
        end
        checks++;
        if (n_mem != 100) begin
            errors++;
            $display("FAIL mem_unbounded: got %0d wait cycles want 100", n_mem);
        end
`endif
    endtask

    task automatic test_random();
        logic [14:0] o, exp;
        logic [15:0] ins;
        logic [4:0]  alu;
        int op, di, dd;
        bit mem, st, wr;
        logic [1:0] wbs;
        apply_reset();
        alu = 5'b11111;
        for (int n = 0; n < 80; n++) begin
            do op = int'($urandom_range(0, 31));
            while (op == 0 || op == 2 || op == 3);
            ins = {5'(op), 11'($urandom)};
            di  = int'($urandom_range(0, 4));
            dd  = int'($urandom_range(0, 4));
            mem = op inside {16, 17, 19};
            st  = op inside {16, 19};
            wr  = m_writes(op);
            wbs = m_wbsel(op);
            instr = ins;
            for (int k = 0; k <= di; k++) begin
                cyc((k == di), 1'($urandom), o);
                exp = {1'b1, (k == di), 4'b0000, 2'b00, 2'b00, alu};
                checks++;
                if (o !== exp) begin
                    errors++;
                    $display("FAIL rand[%0d] fetch: got %h want %h", n, o, exp);
                end
            end
            alu = m_alu(ins);
            instr = 16'($urandom);
            for (int k = 0; k < 2; k++) begin
                cyc(1'($urandom), 1'($urandom), o);
                exp = {6'b000000, 2'b00, 2'b00, alu};
                checks++;
                if (o !== exp) begin
                    errors++;
                    $display("FAIL rand[%0d] dec_ex op=%0d: got %h want %h",
                             n, op, o, exp);
                end
            end
            if (mem) begin
                for (int k = 0; k <= dd; k++) begin
                    cyc(1'($urandom), (k == dd), o);
                    exp = {2'b00, 1'b1, st, 2'b00, 2'b00, 2'b00, alu};
                    checks++;
                    if (o !== exp) begin
                        errors++;
                        $display("FAIL rand[%0d] mem op=%0d: got %h want %h",
                                 n, op, o, exp);
                    end
                end
            end
            cyc(1'($urandom), 1'($urandom), o);
            exp = {4'b0000, 1'b1, wr, wbs, 2'b00, alu};
            checks++;
            if (o !== exp) begin
                errors++;
                $display("FAIL rand[%0d] wb op=%0d: got %h want %h",
                         n, op, o, exp);
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_load();
        test_halt();
        test_illegal();
        test_rst_mid_mem();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
